// File: rtl/vexec_pkg.sv
// Shared types and parameter defaults for the vector execution unit.
// Op/mode encodings match the in_op / in_mode port encodings bit for bit.
package vexec_pkg;

  localparam int XLEN_DEF  = 21;
  localparam int ELEN_DEF  = 24;
  localparam int LANES_DEF = 8;
  localparam int LPC_DEF   = 2;

  typedef enum logic [1:0] {
    MODE_S   = 2'b00,
    MODE_VS  = 2'b01,
    MODE_VV  = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_MINU  = 3'b101,
    OP_MAXU  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_vec(input mode_e m);
    return (m == MODE_VS) || (m == MODE_VV);
  endfunction

endpackage

// File: rtl/vexec_lane.sv
// Width-parametrised single-element unsigned ALU, purely combinational.
// The extra carry/borrow bit drives the optional saturation of ADD/SUB.
module vexec_lane
  import vexec_pkg::*;
#(
  parameter int W = 24
) (
  input  op_e          op,
  input  logic         sat,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:   res = (sat && sum[W])  ? '1 : sum[W-1:0];
      OP_SUB:   res = (sat && diff[W]) ? '0 : diff[W-1:0];
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_MINU:  res = (a < b) ? a : b;
      OP_MAXU:  res = (a > b) ? a : b;
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_unit.sv
// Scalar / vector execution unit: scalar ops finish in one cycle, vector ops
// sweep LPC lanes per beat over LANES/LPC beats, results held until out_ready.
module vec_exec_unit
  import vexec_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ELEN  = ELEN_DEF,
  parameter int LANES = LANES_DEF,
  parameter int LPC   = LPC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_mode,
  input  logic [2:0]            in_op,
  input  logic                  in_sat,
  input  logic                  in_use_imm,
  input  logic [XLEN-1:0]       in_r1e,
  input  logic [XLEN-1:0]       in_r2e,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [LANES*ELEN-1:0] in_r1v,
  input  logic [LANES*ELEN-1:0] in_r2v,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_res_s,
  output logic [LANES*ELEN-1:0] out_res_v,
  output logic                  out_err
);

  localparam int BEATS = LANES / LPC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (LPC < 1 || (LANES % LPC) != 0) begin : g_lpc_check
    $error("vec_exec_unit: LANES must be a multiple of LPC");
  end
  if (ELEN < XLEN) begin : g_elen_check
    $error("vec_exec_unit: ELEN must be >= XLEN");
  end

  state_e                  state_reg, state_next;
  logic [BW-1:0]           beat_reg, beat_next;
  op_e                     op_reg;
  mode_e                   mode_reg;
  logic                    sat_reg;
  logic [XLEN-1:0]         b_reg;
  logic [LANES*ELEN-1:0]   r1v_reg, r2v_reg;
  logic [XLEN-1:0]         res_s_reg;
  logic                    err_reg;

  mode_e                   in_mode_e, cur_mode;
  op_e                     in_op_e, cur_op;
  logic                    idle, accept, proc_v, cur_sat;
  logic [XLEN-1:0]         in_b, cur_b, scalar_res;
  logic [ELEN-1:0]         cur_b_ext;
  logic [LANES*ELEN-1:0]   cur_r1v, cur_r2v;
  logic [ELEN-1:0]         lane_res [LPC];

  assign in_mode_e = mode_e'(in_mode);
  assign in_op_e   = op_e'(in_op);
  assign in_b      = in_use_imm ? in_imm : in_r2e;
  assign idle      = (state_reg == ST_IDLE);
  assign accept    = in_valid && idle;
  assign proc_v    = (accept && is_vec(in_mode_e)) || (state_reg == ST_BUSY);

  // Beat 0 is computed from the live inputs on the accepting edge; later
  // beats read the captured copies, so input changes after acceptance are inert.
  assign cur_op    = idle ? in_op_e   : op_reg;
  assign cur_mode  = idle ? in_mode_e : mode_reg;
  assign cur_sat   = idle ? in_sat    : sat_reg;
  assign cur_b     = idle ? in_b      : b_reg;
  assign cur_r1v   = idle ? in_r1v    : r1v_reg;
  assign cur_r2v   = idle ? in_r2v    : r2v_reg;
  assign cur_b_ext = ELEN'(cur_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_vec(in_mode_e) && BEATS > 1) begin
            state_next = ST_BUSY;
            beat_next  = BW'(1);
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (beat_reg == LAST_BEAT) begin
          state_next = ST_DONE;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + BW'(1);
        end
      end
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    out_valid = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= OP_ADD;
      mode_reg  <= MODE_S;
      sat_reg   <= 1'b0;
      b_reg     <= '0;
      r1v_reg   <= '0;
      r2v_reg   <= '0;
      res_s_reg <= '0;
      err_reg   <= 1'b0;
    end else if (accept) begin
      op_reg    <= in_op_e;
      mode_reg  <= in_mode_e;
      sat_reg   <= in_sat;
      b_reg     <= in_b;
      r1v_reg   <= in_r1v;
      r2v_reg   <= in_r2v;
      res_s_reg <= (in_mode_e == MODE_S) ? scalar_res : '0;
      err_reg   <= (in_mode_e == MODE_ILL);
    end
  end

  vexec_lane #(.W(XLEN)) u_scalar (
    .op  (in_op_e),
    .sat (in_sat),
    .a   (in_r1e),
    .b   (in_b),
    .res (scalar_res)
  );

  for (genvar gi = 0; gi < LPC; gi++) begin : g_lane
    logic [ELEN-1:0] a_l, b_l;
    assign a_l = cur_r1v[(int'(beat_reg) * LPC + gi) * ELEN +: ELEN];
    assign b_l = (cur_mode == MODE_VV) ? cur_r2v[(int'(beat_reg) * LPC + gi) * ELEN +: ELEN]
                                       : cur_b_ext;
    vexec_lane #(.W(ELEN)) u_lane (
      .op  (cur_op),
      .sat (cur_sat),
      .a   (a_l),
      .b   (b_l),
      .res (lane_res[gi])
    );
  end

  // Every result element clears on acceptance, then fills on its own beat.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_res
    localparam logic [BW-1:0] MY_BEAT = BW'(gi / LPC);
    logic [ELEN-1:0] elem_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             elem_reg <= '0;
      else if (proc_v && beat_reg == MY_BEAT) elem_reg <= lane_res[gi % LPC];
      else if (accept)                        elem_reg <= '0;
    end
    assign out_res_v[gi*ELEN +: ELEN] = elem_reg;
  end

  assign out_res_s = res_s_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed table-driven bench for vec_exec_unit (default build plus an LPC=8
// build sharing the same stimulus), with hand sequences for stall and reset.
module tb_vec_exec_unit;

  localparam int XL = 21;
  localparam int EL = 24;
  localparam int NL = 8;
  localparam int VW = NL * EL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready;
  logic [1:0]    in_mode;
  logic [2:0]    in_op;
  logic          in_sat, in_use_imm;
  logic [XL-1:0] in_r1e, in_r2e, in_imm;
  logic [VW-1:0] in_r1v, in_r2v;

  logic          in_ready, out_valid, out_err;
  logic [XL-1:0] out_res_s;
  logic [VW-1:0] out_res_v;
  logic          in_ready8, out_valid8, out_err8;
  logic [XL-1:0] out_res_s8;
  logic [VW-1:0] out_res_v8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_op(in_op), .in_sat(in_sat), .in_use_imm(in_use_imm),
    .in_r1e(in_r1e), .in_r2e(in_r2e), .in_imm(in_imm), .in_r1v(in_r1v), .in_r2v(in_r2v),
    .out_valid(out_valid), .out_ready(out_ready), .out_res_s(out_res_s),
    .out_res_v(out_res_v), .out_err(out_err)
  );

  vec_exec_unit #(.LPC(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .in_mode(in_mode), .in_op(in_op), .in_sat(in_sat), .in_use_imm(in_use_imm),
    .in_r1e(in_r1e), .in_r2e(in_r2e), .in_imm(in_imm), .in_r1v(in_r1v), .in_r2v(in_r2v),
    .out_valid(out_valid8), .out_ready(out_ready), .out_res_s(out_res_s8),
    .out_res_v(out_res_v8), .out_err(out_err8)
  );

  typedef struct {
    string         name;
    logic [1:0]    mode;
    logic [2:0]    op;
    logic          sat;
    logic          use_imm;
    logic [XL-1:0] r1e, r2e, imm;
    logic [VW-1:0] r1v, r2v;
    logic [XL-1:0] exp_s;
    logic [VW-1:0] exp_v;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [VW-1:0] pk8(input logic [EL-1:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  function automatic logic [VW-1:0] splat(input logic [EL-1:0] x);
    return {x, x, x, x, x, x, x, x};
  endfunction

  function automatic vec_t mkv(input string name, input logic [1:0] mode, input logic [2:0] op,
                               input logic sat, input logic use_imm,
                               input logic [XL-1:0] r1e, r2e, imm,
                               input logic [VW-1:0] r1v, r2v,
                               input logic [XL-1:0] exp_s, input logic [VW-1:0] exp_v,
                               input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.mode = mode; v.op = op; v.sat = sat; v.use_imm = use_imm;
    v.r1e = r1e; v.r2e = r2e; v.imm = imm; v.r1v = r1v; v.r2v = r2v;
    v.exp_s = exp_s; v.exp_v = exp_v; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scramble();
    logic [31:0] rnd;
    rnd = $urandom; in_r1e = rnd[XL-1:0];
    rnd = $urandom; in_r2e = rnd[XL-1:0];
    rnd = $urandom; in_imm = rnd[XL-1:0];
    rnd = $urandom; in_op = rnd[2:0]; in_sat = rnd[3]; in_use_imm = rnd[4];
    in_r1v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_r2v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive(input vec_t v);
    in_mode = v.mode; in_op = v.op; in_sat = v.sat; in_use_imm = v.use_imm;
    in_r1e = v.r1e; in_r2e = v.r2e; in_imm = v.imm; in_r1v = v.r1v; in_r2v = v.r2v;
  endtask

  task automatic do_vec(input vec_t v);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    check({v.name, "/lpc8_valid"}, VW'(out_valid8), VW'(1'b1));
    check({v.name, "/lpc8_res_s"}, VW'(out_res_s8), VW'(v.exp_s));
    check({v.name, "/lpc8_res_v"}, out_res_v8, v.exp_v);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    check({v.name, "/latency"}, VW'(lat), VW'(v.exp_lat));
    check({v.name, "/res_s"}, VW'(out_res_s), VW'(v.exp_s));
    check({v.name, "/res_v"}, out_res_v, v.exp_v);
    check({v.name, "/err"}, VW'(out_err), VW'(v.exp_err));
    check({v.name, "/ready_low"}, VW'(busy_ok), VW'(1'b1));
    $display("op %s: lat=%0d res_s=%0h res_v=%0h err=%0b", v.name, lat, out_res_s, out_res_v, out_err);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({v.name, "/release_valid"}, VW'(out_valid), VW'(1'b0));
    check({v.name, "/release_ready"}, VW'(in_ready), VW'(1'b1));
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stable_ok, quiet_ok;
    vec_t bp, rv;

    tbl[0]  = mkv("s_add_wrap",  2'b00, 3'd0, 1'b0, 1'b1, 21'h1FFFFF, 21'h0, 21'h1, '0, '0, 21'h0, '0, 1'b0, 1);
    tbl[1]  = mkv("s_add_sat",   2'b00, 3'd0, 1'b1, 1'b1, 21'h1FFFFF, 21'h0, 21'h1, '0, '0, 21'h1FFFFF, '0, 1'b0, 1);
    tbl[2]  = mkv("s_sub_wrap",  2'b00, 3'd1, 1'b0, 1'b0, 21'h2, 21'h3, 21'h0, '0, '0, 21'h1FFFFF, '0, 1'b0, 1);
    tbl[3]  = mkv("s_sub_sat",   2'b00, 3'd1, 1'b1, 1'b0, 21'h2, 21'h3, 21'h0, '0, '0, 21'h0, '0, 1'b0, 1);
    tbl[4]  = mkv("s_and",       2'b00, 3'd2, 1'b1, 1'b0, 21'h1F0F0F, 21'h0FF0F0, 21'h0, '0, '0, 21'h0F0000, '0, 1'b0, 1);
    tbl[5]  = mkv("s_or",        2'b00, 3'd3, 1'b0, 1'b0, 21'h1F0F0F, 21'h0FF0F0, 21'h0, '0, '0, 21'h1FFFFF, '0, 1'b0, 1);
    tbl[6]  = mkv("s_minu",      2'b00, 3'd5, 1'b0, 1'b0, 21'h100000, 21'h0FFFFF, 21'h0, '0, '0, 21'h0FFFFF, '0, 1'b0, 1);
    tbl[7]  = mkv("s_maxu",      2'b00, 3'd6, 1'b0, 1'b0, 21'h100000, 21'h0FFFFF, 21'h0, '0, '0, 21'h100000, '0, 1'b0, 1);
    tbl[8]  = mkv("s_passb",     2'b00, 3'd7, 1'b0, 1'b1, 21'h1, 21'h54321, 21'h12345, '0, '0, 21'h12345, '0, 1'b0, 1);
    tbl[9]  = mkv("vv_sub_sat",  2'b10, 3'd1, 1'b1, 1'b0, 21'h0, 21'h0, 21'h0, splat(24'h5), splat(24'h7),
                  21'h0, '0, 1'b0, 4);
    tbl[10] = mkv("vs_xor",      2'b01, 3'd4, 1'b0, 1'b0, 21'h0, 21'hF, 21'h3,
                  pk8(24'h0, 24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6, 24'h7), '0,
                  21'h0, pk8(24'hF, 24'hE, 24'hD, 24'hC, 24'hB, 24'hA, 24'h9, 24'h8), 1'b0, 4);
    tbl[11] = mkv("vv_add_sat",  2'b10, 3'd0, 1'b1, 1'b0, 21'h0, 21'h0, 21'h0,
                  pk8(24'hFFFFF0, 24'hFFFFF1, 24'hFFFFF2, 24'hFFFFF3, 24'hFFFFF4, 24'hFFFFF5, 24'hFFFFF6, 24'hFFFFF7),
                  pk8(24'h0, 24'h2, 24'h4, 24'h6, 24'h8, 24'hA, 24'hC, 24'hE), 21'h0,
                  pk8(24'hFFFFF0, 24'hFFFFF3, 24'hFFFFF6, 24'hFFFFF9, 24'hFFFFFC, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF),
                  1'b0, 4);
    tbl[12] = mkv("vs_add_zext", 2'b01, 3'd0, 1'b0, 1'b1, 21'h0, 21'h0, 21'h1FFFFF,
                  pk8(24'hE00000, 24'hE00001, 24'hE00002, 24'hE00003, 24'hE00004, 24'hE00005, 24'hE00006, 24'hE00007),
                  '0, 21'h0, pk8(24'hFFFFFF, 24'h0, 24'h1, 24'h2, 24'h3, 24'h4, 24'h5, 24'h6), 1'b0, 4);
    tbl[13] = mkv("vv_minu",     2'b10, 3'd5, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0,
                  pk8(24'h0, 24'h100000, 24'h200000, 24'h300000, 24'h400000, 24'h500000, 24'h600000, 24'h700000),
                  splat(24'h350000), 21'h0,
                  pk8(24'h0, 24'h100000, 24'h200000, 24'h300000, 24'h350000, 24'h350000, 24'h350000, 24'h350000),
                  1'b0, 4);
    tbl[14] = mkv("vv_maxu",     2'b10, 3'd6, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0,
                  pk8(24'h0, 24'h100000, 24'h200000, 24'h300000, 24'h400000, 24'h500000, 24'h600000, 24'h700000),
                  splat(24'h350000), 21'h0,
                  pk8(24'h350000, 24'h350000, 24'h350000, 24'h350000, 24'h400000, 24'h500000, 24'h600000, 24'h700000),
                  1'b0, 4);
    tbl[15] = mkv("vv_passb",    2'b10, 3'd7, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, splat(24'h123),
                  pk8(24'hA00000, 24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004, 24'hA00005, 24'hA00006, 24'hA00007),
                  21'h0,
                  pk8(24'hA00000, 24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004, 24'hA00005, 24'hA00006, 24'hA00007),
                  1'b0, 4);
    tbl[16] = mkv("vs_passb",    2'b01, 3'd7, 1'b0, 1'b0, 21'h0, 21'h1ABCDE, 21'h0, splat(24'h1), '0,
                  21'h0, splat(24'h1ABCDE), 1'b0, 4);
    tbl[17] = mkv("illegal",     2'b11, 3'd0, 1'b0, 1'b0, 21'h3, 21'h4, 21'h0, splat(24'h1), splat(24'h1),
                  21'h0, '0, 1'b1, 1);
    tbl[18] = mkv("vv_and",      2'b10, 3'd2, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, splat(24'hFFFF00), splat(24'h0F0F0F),
                  21'h0, splat(24'h0F0F00), 1'b0, 4);
    tbl[19] = mkv("vv_sub_wrap", 2'b10, 3'd1, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, splat(24'h5), splat(24'h7),
                  21'h0, splat(24'hFFFFFE), 1'b0, 4);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(tbl[0]);
    #3;
    check("reset/out_valid", VW'(out_valid), VW'(1'b0));
    check("reset/in_ready", VW'(in_ready), VW'(1'b1));
    check("reset/res_s", VW'(out_res_s), '0);
    check("reset/res_v", out_res_v, '0);
    check("reset/err", VW'(out_err), VW'(1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) do_vec(tbl[i]);

    // Back-pressure: hold DONE for 10 cycles while offering other operations.
    bp = mkv("bp_xor", 2'b00, 3'd4, 1'b0, 1'b1, 21'h0AAAAA, 21'h0, 21'h155555, '0, '0, 21'h1FFFFF, '0, 1'b0, 1);
    @(negedge clk);
    drive(bp);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp/valid", VW'(out_valid), VW'(1'b1));
    check("bp/res_s", VW'(out_res_s), VW'(bp.exp_s));
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(tbl[11]);
      in_valid = c[0];
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res_s !== bp.exp_s ||
          out_res_v !== '0 || out_err !== 1'b0) stable_ok = 1'b0;
    end
    check("bp/stable", VW'(stable_ok), VW'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp/release_valid", VW'(out_valid), VW'(1'b0));
    check("bp/release_ready", VW'(in_ready), VW'(1'b1));
    out_ready = 1'b0;
    quiet_ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet_ok = 1'b0;
    end
    check("bp/no_ghost_op", VW'(quiet_ok), VW'(1'b1));
    $display("op bp_xor: held 10 cycles, res_s=%0h", out_res_s);

    // Reset while the vector op is on beat 2.
    rv = mkv("rst_vv", 2'b10, 3'd0, 1'b0, 1'b0, 21'h0, 21'h0, 21'h0, splat(24'h1), splat(24'h1),
             21'h0, splat(24'h2), 1'b0, 4);
    @(negedge clk);
    drive(rv);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst/partial_seen", out_res_v, {96'h0, splat(24'h2)} & {{96{1'b0}}, {96{1'b1}}});
    rst_n = 1'b0;
    #1;
    check("rst/res_v", out_res_v, '0);
    check("rst/valid", VW'(out_valid), VW'(1'b0));
    check("rst/res_s", VW'(out_res_s), '0);
    check("rst/err", VW'(out_err), VW'(1'b0));
    check("rst/ready", VW'(in_ready), VW'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out_res_v !== '0) quiet_ok = 1'b0;
    end
    check("rst/no_result_after", VW'(quiet_ok), VW'(1'b1));
    $display("op rst_vv: reset on beat 2, out_valid=%0b res_v=%0h", out_valid, out_res_v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
